// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates a mechanical key press/release on an active-low line,
// with LFSR-timed contact bounce before and after a programmable stable-low hold.
module key_bounce_gen #(
    parameter int          BOUNCE_NUM = 3,
    parameter int          BOUNCE_W   = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        press_req,
    input  logic        abort,
    input  logic [19:0] hold_cycles,
    output logic        key_out,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, BOUNCE_DN, HOLD, BOUNCE_UP} state_t;

    localparam logic [BOUNCE_W:0] SEG_ONE  = {{BOUNCE_W{1'b0}}, 1'b1};
    localparam logic [4:0]        SEG_LAST = 5'(2 * BOUNCE_NUM - 1);
    localparam logic              HAS_BNC  = BOUNCE_NUM > 0;

    state_t            state_q, state_d;
    logic              key_q, key_d, busy_q, busy_d, done_q, done_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [BOUNCE_W:0] seg_cnt_q, seg_cnt_d, seg_w;
    logic [4:0]        seg_idx_q, seg_idx_d;
    logic [19:0]       hold_cnt_q, hold_cnt_d, hold_q, hold_d, hold_eff;

    assign seg_w    = {1'b0, lfsr_q[BOUNCE_W-1:0]} + SEG_ONE;
    assign hold_eff = (hold_cycles == 20'd0) ? 20'd1 : hold_cycles;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        done_d     = 1'b0;
        seg_cnt_d  = seg_cnt_q;
        seg_idx_d  = seg_idx_q;
        hold_cnt_d = hold_cnt_q;
        hold_d     = hold_q;
        // Galois form of x^16+x^14+x^13+x^11+1, free-running
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        case (state_q)
            IDLE: begin
                if (press_req && !abort) begin
                    key_d     = 1'b0;
                    hold_d    = hold_eff;
                    seg_idx_d = 5'd0;
                    if (HAS_BNC) begin
                        state_d   = BOUNCE_DN;
                        seg_cnt_d = seg_w;
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = hold_eff;
                    end
                end
            end
            BOUNCE_DN, BOUNCE_UP: begin
                if (seg_cnt_q == SEG_ONE) begin
                    if (seg_idx_q == SEG_LAST) begin
                        seg_idx_d = 5'd0;
                        seg_cnt_d = '0;
                        key_d     = (state_q == BOUNCE_UP);
                        if (state_q == BOUNCE_DN) begin
                            state_d    = HOLD;
                            hold_cnt_d = hold_q;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        seg_idx_d = seg_idx_q + 5'd1;
                        seg_cnt_d = seg_w;
                        key_d     = ~key_q;
                    end
                end else begin
                    seg_cnt_d = seg_cnt_q - SEG_ONE;
                end
            end
            HOLD: begin
                if (hold_cnt_q == 20'd1) begin
                    hold_cnt_d = 20'd0;
                    key_d      = 1'b1;
                    if (HAS_BNC) begin
                        state_d   = BOUNCE_UP;
                        seg_cnt_d = seg_w;
                        seg_idx_d = 5'd0;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 20'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort overrides everything, including a completing sequence's done
        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            key_d      = 1'b1;
            done_d     = 1'b0;
            seg_cnt_d  = '0;
            seg_idx_d  = 5'd0;
            hold_cnt_d = 20'd0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lfsr_q     <= SEED;
            seg_cnt_q  <= '0;
            seg_idx_q  <= 5'd0;
            hold_cnt_q <= 20'd0;
            hold_q     <= 20'd0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            lfsr_q     <= lfsr_d;
            seg_cnt_q  <= seg_cnt_d;
            seg_idx_q  <= seg_idx_d;
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign key_out = key_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen: two instances (no bounce, 3 bounce pairs) checked every cycle
// against a waveform-queue model built from segment widths, plus directed checks.
module tb_key_bounce_gen;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam logic [2:0]  IDLE_E = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        press_v [2];
    logic        abort_v [2];
    logic [19:0] hold_v  [2];
    logic        key_v   [2];
    logic        busy_v  [2];
    logic        done_v  [2];

    int total = 0, bad = 0;
    int runs[$], ra[$];
    int lows, dones, rises, falls, ncyc;

    always #5 clk = ~clk;

    function automatic logic [15:0] nx(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) v = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
        return v;
    endfunction

    // model: on acceptance, the whole expected {key,busy,done} waveform is queued
    for (genvar g = 0; g < 2; g++) begin : m
        localparam int N = 3 * g;
        logic [2:0]  cur;
        logic [15:0] lf;
        logic [2:0]  q[$];
        int          wq[$];

        key_bounce_gen #(.BOUNCE_NUM(N), .BOUNCE_W(4), .SEED(SEED)) dut (
            .clk(clk), .rst(rst), .press_req(press_v[g]), .abort(abort_v[g]),
            .hold_cycles(hold_v[g]), .key_out(key_v[g]), .busy(busy_v[g]), .done(done_v[g])
        );

        always @(posedge clk or posedge rst) begin : mdl
            logic [15:0] l;
            int h, w;
            if (rst) begin
                cur <= IDLE_E;
                lf  <= SEED;
                q.delete();
            end else begin
                lf <= nx(lf, 1);
                if (abort_v[g] && cur[1]) begin
                    q.delete();
                    cur <= IDLE_E;
                end else if (!cur[1] && press_v[g] && !abort_v[g]) begin
                    l = lf;
                    h = (hold_v[g] == 20'd0) ? 1 : int'(hold_v[g]);
                    wq.delete();
                    for (int s = 0; s < 2 * N; s++) begin
                        w = int'(l[3:0]) + 1;
                        wq.push_back(w);
                        for (int c = 0; c < w; c++) q.push_back({s[0], 2'b10});
                        l = nx(l, w);
                    end
                    for (int c = 0; c < h; c++) q.push_back(3'b010);
                    l = nx(l, h);
                    for (int s = 0; s < 2 * N; s++) begin
                        w = int'(l[3:0]) + 1;
                        wq.push_back(w);
                        for (int c = 0; c < w; c++) q.push_back({~s[0], 2'b10});
                        l = nx(l, w);
                    end
                    q.push_back(3'b101);
                    cur <= q.pop_front();
                end else begin
                    cur <= (q.size() > 0) ? q.pop_front() : IDLE_E;
                end
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        total++;
        assert ({key_v[0], busy_v[0], done_v[0]} === m[0].cur) else begin
            bad++;
            $error("FAIL inst0 kbd got=%b exp=%b t=%0t", {key_v[0], busy_v[0], done_v[0]}, m[0].cur, $time);
        end
        total++;
        assert ({key_v[1], busy_v[1], done_v[1]} === m[1].cur) else begin
            bad++;
            $error("FAIL inst1 kbd got=%b exp=%b t=%0t", {key_v[1], busy_v[1], done_v[1]}, m[1].cur, $time);
        end
    endtask

    // one press, then run until busy drops, collecting run lengths and edge counts
    task automatic seq(input int g, input logic [19:0] h);
        logic pk;
        int rl;
        press_v[g] = 1'b1;
        hold_v[g]  = h;
        runs.delete();
        lows = 0; dones = 0; rises = 0; falls = 0; ncyc = 0; rl = 0; pk = 1'b1;
        do begin
            cyc();
            press_v[g] = 1'b0;
            ncyc++;
            if (key_v[g] !== pk) begin
                if (ncyc > 1) runs.push_back(rl);
                rl = 0;
                if (key_v[g]) rises++; else falls++;
            end
            rl++;
            pk = key_v[g];
            lows  += int'(!key_v[g]);
            dones += int'(done_v[g]);
        end while (busy_v[g] && ncyc < 3000);
        chk("seq_timeout", int'(ncyc < 3000), 1);
    endtask

    initial begin
        int dn, j;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            press_v[g] = 1'b0;
            abort_v[g] = 1'b0;
            hold_v[g]  = 20'd0;
        end
        repeat (3) cyc();
        for (int g = 0; g < 2; g++) begin
            chk("rst_key", int'(key_v[g]), 1);
            chk("rst_busy", int'(busy_v[g]), 0);
            chk("rst_done", int'(done_v[g]), 0);
        end
        rst = 1'b0;

        seq(0, 20'd5);
        chk("n0_low", lows, 5);
        chk("n0_len", ncyc, 6);
        chk("n0_done", dones, 1);
        chk("n0_runs", runs.size(), 1);

        seq(0, 20'd0);
        chk("h0_low", lows, 1);
        chk("h0_done", dones, 1);

        seq(1, 20'd100);
        chk("b3_rises", rises, 7);
        chk("b3_falls", falls, 7);
        chk("b3_nruns", runs.size(), 13);
        chk("b3_nwq", m[1].wq.size(), 12);
        if (runs.size() == 13 && m[1].wq.size() == 12) begin
            chk("b3_hold", runs[6], 100);
            j = 0;
            for (int i = 0; i < 13; i++) begin
                if (i != 6) begin
                    chk("b3_seg", runs[i], m[1].wq[j]);
                    chk("b3_seg_rng", int'(runs[i] >= 1 && runs[i] <= 16), 1);
                    j++;
                end
            end
        end

        press_v[0] = 1'b1; hold_v[0] = 20'd50;
        cyc();
        press_v[0] = 1'b0;
        repeat (9) cyc();
        abort_v[0] = 1'b1;
        cyc();
        abort_v[0] = 1'b0;
        chk("ab_key", int'(key_v[0]), 1);
        chk("ab_busy", int'(busy_v[0]), 0);
        dn = int'(done_v[0]);
        repeat (5) begin cyc(); dn += int'(done_v[0]); end
        chk("ab_nodone", dn, 0);
        seq(0, 20'd3);
        chk("ab_next_low", lows, 3);
        chk("ab_next_done", dones, 1);

        press_v[0] = 1'b1; abort_v[0] = 1'b1;
        cyc();
        press_v[0] = 1'b0; abort_v[0] = 1'b0;
        chk("ab_pr_busy", int'(busy_v[0]), 0);
        chk("ab_pr_key", int'(key_v[0]), 1);

        press_v[0] = 1'b1; hold_v[0] = 20'd4;
        cyc();
        press_v[0] = 1'b0;
        repeat (3) cyc();
        abort_v[0] = 1'b1;
        cyc();
        abort_v[0] = 1'b0;
        chk("ab_end_done", int'(done_v[0]), 0);
        chk("ab_end_busy", int'(busy_v[0]), 0);
        cyc();

        press_v[1] = 1'b1; hold_v[1] = 20'd20;
        cyc();
        dn = 0; j = 0;
        while (m[1].cur[1] && j < 3000) begin
            press_v[1] = 1'($urandom);
            cyc();
            j++;
            dn += int'(done_v[1]);
        end
        press_v[1] = 1'b0;
        repeat (10) begin cyc(); dn += int'(done_v[1]); end
        chk("one_done", dn, 1);
        chk("one_idle", int'(busy_v[1]), 0);

        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        seq(1, 20'd30);
        ra = runs;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        press_v[1] = 1'b1; hold_v[1] = 20'd30;
        cyc();
        press_v[1] = 1'b0;
        repeat (2) cyc();
        chk("mid_dn_busy", int'(busy_v[1]), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_key", int'(key_v[1]), 1);
        chk("async_busy", int'(busy_v[1]), 0);
        chk("async_done", int'(done_v[1]), 0);
        cyc();
        cyc();
        rst = 1'b0;
        seq(1, 20'd30);
        chk("rerun_nruns", runs.size(), ra.size());
        if (runs.size() == ra.size())
            for (int i = 0; i < runs.size(); i++) chk("rerun_seg", runs[i], ra[i]);

        for (int i = 0; i < 600; i++) begin
            for (int g = 0; g < 2; g++) begin
                press_v[g] = ($urandom_range(0, 7) == 0);
                abort_v[g] = ($urandom_range(0, 40) == 0);
                hold_v[g]  = 20'($urandom_range(0, 30));
            end
            cyc();
        end
        for (int g = 0; g < 2; g++) begin
            press_v[g] = 1'b0;
            abort_v[g] = 1'b0;
        end
        repeat (5) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
